// File: rtl/onehot_seq_pkg.sv
// Shared types and helpers for the registered one-hot select sequencer.
// Scan support is built only when ONEHOT_SEQ_SCAN_EN is defined.
package onehot_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int onehot_width(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational index to one-hot decoder; generalises the old 2-bit K-map
// generator to any select width.
module onehot_decoder
    import onehot_seq_pkg::*;
#(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]               i_sel,
    output logic [onehot_width(SEL_W)-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_sel] = 1'b1;
    end

endmodule

// File: rtl/onehot_seq_decoder.sv
// Registered one-hot mux-select driver with direct (handshaked) and scan modes.
// Scan mode and its dwell counter exist only when ONEHOT_SEQ_SCAN_EN is defined.
module onehot_seq_decoder
    import onehot_seq_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SEL_W-1:0]               in_sel,
    input  logic                           start,
    input  logic                           stop,
    input  logic [DWELL_W-1:0]             dwell,
    output logic [onehot_width(SEL_W)-1:0] mux_in,
    output logic                           out_valid,
    output logic                           busy
);

    localparam int W = onehot_width(SEL_W);

    logic [W-1:0] w_dec;
    logic [W-1:0] r_mux;
    logic         r_ov;
    logic         w_hs;

    onehot_decoder #(.SEL_W(SEL_W)) u_dec (
        .i_sel    (in_sel),
        .o_onehot (w_dec)
    );

    assign mux_in    = r_mux;
    assign out_valid = r_ov;
    assign w_hs      = in_valid && in_ready;

`ifdef ONEHOT_SEQ_SCAN_EN

    state_t             r_state;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [SEL_W-1:0]   r_pos;
    logic               r_busy;

    assign busy     = r_busy;
    assign in_ready = (r_state == ST_IDLE) && (mode == MODE_DIRECT) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mux   <= '0;
            r_ov    <= 1'b0;
            r_busy  <= 1'b0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_pos   <= '0;
        end else begin
            r_ov <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (mode == MODE_SCAN && start) begin
                        r_state <= ST_SCAN;
                        r_busy  <= 1'b1;
                        r_dwell <= dwell;
                        r_cnt   <= '0;
                        r_pos   <= '0;
                        r_mux   <= W'(1);
                        r_ov    <= 1'b1;
                    end else if (w_hs) begin
                        r_mux <= w_dec;
                        r_ov  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    // stop takes priority over a coinciding advance
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == r_dwell) begin
                        r_cnt <= '0;
                        r_pos <= r_pos + 1'b1;
                        r_mux <= {r_mux[W-2:0], r_mux[W-1]};
                        r_ov  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`else

    logic w_unused;

    assign w_unused = ^{mode, start, stop, dwell};
    assign busy     = 1'b0;
    assign in_ready = !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mux <= '0;
            r_ov  <= 1'b0;
        end else begin
            r_ov <= w_hs;
            if (w_hs) begin
                r_mux <= w_dec;
            end
        end
    end

`endif

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Self-checking bench for onehot_seq_decoder against a timeline model.
// Scan scenarios run only when ONEHOT_SEQ_SCAN_EN is defined.
module tb_onehot_seq_decoder;

    localparam int SEL_W   = 2;
    localparam int DWELL_W = 4;
    localparam int N       = 4;
`ifdef ONEHOT_SEQ_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               mode = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [N-1:0]       mux_in;
    logic               out_valid;
    logic               busy;

    int checks = 0;
    int errors = 0;

    // model: scan position is derived from cycles elapsed since scan start
    bit           m_scan = 1'b0;
    int           m_t    = 0;
    int           m_d    = 0;
    logic [N-1:0] m_mux  = '0;
    logic         m_ov   = 1'b0;

    always #5 clk = ~clk;

    onehot_seq_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .start     (start),
        .stop      (stop),
        .dwell     (dwell),
        .mux_in    (mux_in),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        logic exp_rdy;
        #1;
        exp_rdy = !reset && !m_scan && (!SCAN_EN || !mode);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (reset) begin
            m_scan = 1'b0;
            m_mux  = '0;
            m_ov   = 1'b0;
        end else if (!m_scan) begin
            if (SCAN_EN && mode && start) begin
                m_scan = 1'b1;
                m_d    = int'(dwell);
                m_t    = 0;
                m_mux  = N'(1);
                m_ov   = 1'b1;
            end else if (exp_rdy && in_valid) begin
                m_mux = N'(1 << in_sel);
                m_ov  = 1'b1;
            end else begin
                m_ov = 1'b0;
            end
        end else if (stop) begin
            m_scan = 1'b0;
            m_ov   = 1'b0;
        end else begin
            m_t++;
            m_ov  = (m_t % (m_d + 1)) == 0;
            m_mux = N'(1 << ((m_t / (m_d + 1)) % N));
        end
        @(posedge clk);
        #1;
        chk({tag, ".mux_in"}, 32'(mux_in), 32'(m_mux));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".busy"}, 32'(busy), 32'(m_scan));
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // reset held two cycles
        reset = 1'b1;
        step("rst0");
        step("rst1");
        reset = 1'b0;
        step("idle");

        // direct back-to-back
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_sel = SEL_W'(i);
            step("direct");
        end
        chk("direct.last", 32'(mux_in), 32'h8);
        in_valid = 1'b0;
        step("direct.hold");
        in_valid = 1'b1;
        in_sel   = 2'd3;
        step("direct.repeat");

`ifdef ONEHOT_SEQ_SCAN_EN
        // scan dwell=2 with blocked handshake alongside
        mode  = 1'b1;
        dwell = 4'd2;
        start = 1'b1;
        step("scan.start");
        start = 1'b0;
        for (int i = 0; i < 13; i++) step("scan.dwell2");
        chk("scan.wrap", 32'(mux_in), 32'h1);
        stop = 1'b1;
        step("scan.stop");
        stop     = 1'b0;
        in_valid = 1'b0;

        // stop coinciding with 0100 -> 1000 advance
        dwell = 4'd0;
        start = 1'b1;
        step("stopadv.start");
        start = 1'b0;
        step("stopadv.s1");
        step("stopadv.s2");
        stop = 1'b1;
        step("stopadv.stop");
        chk("stopadv.held", 32'(mux_in), 32'h4);
        stop = 1'b0;
        mode = 1'b0;
        step("stopadv.idle");

        // reset while at 0010
        mode  = 1'b1;
        dwell = 4'd1;
        start = 1'b1;
        step("rstmid.start");
        start = 1'b0;
        step("rstmid.s1");
        step("rstmid.s2");
        chk("rstmid.pos1", 32'(mux_in), 32'h2);
        reset = 1'b1;
        step("rstmid.reset");
        reset = 1'b0;
        start = 1'b1;
        step("rstmid.restart");
        start = 1'b0;
        chk("rstmid.bit0", 32'(mux_in), 32'h1);
        stop = 1'b1;
        step("rstmid.stop");
        stop = 1'b0;
`else
        // scan not built: start ignored, handshake still works in mode 1
        mode     = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 2'd0;
        step("noscan.a");
        in_sel = 2'd3;
        step("noscan.b");
        chk("noscan.sel3", 32'(mux_in), 32'h8);
        start = 1'b0;
        mode  = 1'b0;
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            mode     = 1'($urandom);
            in_valid = 1'($urandom);
            in_sel   = SEL_W'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            dwell    = DWELL_W'($urandom_range(0, 3));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_seq_decoder.md
# onehot_seq_decoder

Parametrised, registered successor to the two-input K-map one-hot generator. Drives a `2**SEL_W`-bit one-hot mux-select word `mux_in` in one of two modes:
- **Direct:** decodes a select value accepted over a valid/ready handshake.
- **Scan:** walks the one-hot bit through every position, holding each for a programmable dwell.

It sits between the control logic and the downstream wide mux. It replaces the fixed 2-bit combinational decoder wherever a registered, sequenced select is needed.

## Interface
Single clock domain. Reset is synchronous and active-high.

Parameters:
- `SEL_W`, default 2: select width; `mux_in` is `2**SEL_W` bits.
- `DWELL_W`, default 4: width of the dwell count.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `mode` in 1: 0 = direct, 1 = scan; sampled only in IDLE.
- `in_valid` in 1: direct-mode select valid.
- `in_ready` out 1: direct-mode select ready.
- `in_sel` in `SEL_W`: select index to decode.
- `start` in 1: scan start pulse.
- `stop` in 1: scan stop request.
- `dwell` in `DWELL_W`: cycles-per-position minus 1; sampled on scan start.
- `mux_in` out `2**SEL_W`: registered one-hot select word (all-zero only after reset).
- `out_valid` out 1: one-cycle pulse whenever `mux_in` changes value or is rewritten.
- `busy` out 1: high while in SCAN.

## Operation
- **States:** IDLE, SCAN. Encoding lives in the package.
- **Reset values:** state IDLE, `mux_in`=0, `out_valid`=0, `busy`=0, dwell counter=0, position=0.
- **`in_ready`:** equals (state==IDLE && mode==0 && !reset). It is combinational from the state register and `mode`.
- **Direct mode (IDLE, mode=0):**
  - Handshake occurs when `in_valid && in_ready`.
  - On the handshake edge, `mux_in` <= 1<<`in_sel` and `out_valid` <= 1.
  - `mux_in` holds until the next handshake.
  - A repeated identical select still pulses `out_valid`.
- **Scan start (IDLE, mode=1, start=1):**
  - Go to SCAN. Latch `dwell`.
  - `mux_in` <= bit 0, `out_valid` <= 1, counter <= 0.
  - `in_valid` is ignored because `in_ready`=0.
- **In SCAN:**
  - The counter increments each cycle.
  - When the counter equals the latched dwell: the position advances, `mux_in` rotates left by one, `out_valid` pulses, and the counter clears.
  - Position `2**SEL_W-1` wraps to bit 0.
- **Stop (SCAN, stop=1):**
  - Return to IDLE on the next edge. `mux_in` retains its current value; `out_valid` does not pulse.
  - If `stop` coincides with an advance edge, stop wins and there is no advance.
- **Start ignored:** `start` is ignored while in SCAN, and in IDLE when mode=0.
- **Mode in SCAN:** changing `mode` during SCAN has no effect.
- **Dwell=0:** the scan advances every cycle.
- **Reset mid-scan:** returns all registers to their reset values on the same edge.

## Timing
- **Direct latency:** a handshake at edge k makes the new `mux_in` and `out_valid`=1 visible after edge k. Sustained throughput is one select per cycle.
- **Scan start latency:** `start` sampled at edge k puts bit 0 on `mux_in` after edge k.
- **Scan dwell:** each position is held for exactly `dwell`+1 cycles.
- **Scan period:** a full scan period is `2**SEL_W`·(`dwell`+1) cycles.
- **`busy`:** rises with the SCAN entry edge and falls with the IDLE entry edge.
- **Glitch-free output:** all outputs except `in_ready` are registered.

## Configuration
- **Macro:** `ONEHOT_SEQ_SCAN_EN`.
- **Defined:** the full behaviour above.
- **Undefined:** the SCAN state and dwell counter are not built. `mode`, `start`, `stop` and `dwell` remain ports but are ignored, and mode is treated as 0. `busy` is tied to 0, and `in_ready` = !`reset`.

## Structure
- **Package `onehot_seq_pkg`:**
  - state enum (IDLE, SCAN);
  - mode constants `MODE_DIRECT`=0 and `MODE_SCAN`=1;
  - a function returning the one-hot width from `SEL_W`.
- **Sub-module `onehot_decoder`:** combinational, parameterised by `SEL_W`, mapping index to the one-hot word. It is the generalised form of the original 2-bit decoder. It is instantiated once for the direct path; scan uses rotation.

## Test plan
Parameters for all scenarios: `SEL_W`=2, `DWELL_W`=4.
1. **Reset:** assert `reset` 2 cycles -> `mux_in`=0000, `out_valid`=0, `busy`=0, `in_ready`=0 during reset and 1 after (mode=0).
2. **Direct back-to-back:** `in_sel` 0,1,2,3 with `in_valid` held -> `mux_in` 0001, 0010, 0100, 1000 on consecutive cycles, `out_valid` high 4 cycles.
3. **Scan with dwell:** mode=1, `dwell`=2, `start` pulse -> `mux_in` 0001×3, 0010×3, 0100×3, 1000×3, then 0001 (wrap), one `out_valid` per change, `busy`=1.
4. **Stop on an advance edge:** `dwell`=0 scan, assert `stop` on the edge that would move 0100→1000 -> `mux_in` stays 0100, `busy` falls, `in_ready` rises when mode=0.
5. **Reset mid-scan:** `reset` during position 0010 -> `mux_in`=0000 next cycle, state IDLE; a later `start` restarts at 0001.
6. **Handshake blocked in scan:** `in_valid`=1 with `in_sel`=3 while `busy` -> `in_ready`=0 and no effect on the scan sequence. With `ONEHOT_SEQ_SCAN_EN` undefined, `start` with mode=1 is ignored and `in_sel`=3 gives `mux_in`=1000.
